// File: rtl/ex_stage_pkg.sv
// Shared widths, ID/EX record layout and lane-mask helper for the MIPS execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD        = 161;
    localparam int EX_TO_MEM_WD       = 76;
    localparam int EX_TO_ID_WD        = 38;
    localparam int LOAD_SRAM_DATA_WD  = 5;
    localparam int STORE_SRAM_DATA_WD = 3;
    localparam int STALL_WD           = 6;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int DIV_SIGNED = 1;

    localparam int HILO_MFHI = 3;
    localparam int HILO_MFLO = 2;
    localparam int HILO_MTHI = 1;
    localparam int HILO_MTLO = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [11:0] alu_op;
        logic [1:0]  div_op;
        logic [3:0]  hilo_op;
        logic [4:0]  load;
        logic [2:0]  store;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] rt_data;
    } id_to_ex_t;

    // Byte lanes touched by an access; halfword ignores addr[0], word ignores both bits.
    function automatic logic [3:0] lane_mask(input logic [1:0] addr, input logic is_byte,
                                             input logic is_half, input logic is_word);
        logic [3:0] m;
        m = 4'b0000;
        if (is_word)
            m = 4'b1111;
        else if (is_half)
            m = addr[1] ? 4'b1100 : 4'b0011;
        else if (is_byte)
            m = 4'b0001 << addr;
        return m;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-facing bus bundle of the execute stage: ID/EX input, MEM/ID outputs and data-SRAM request.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [STALL_WD-1:0]           stall;
    logic [ID_TO_EX_WD-1:0]        id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0]       ex_to_mem_bus;
    logic [EX_TO_ID_WD-1:0]        ex_to_id_bus;
    logic                          ex_is_load;
    logic                          stallreq_for_ex;
    logic [LOAD_SRAM_DATA_WD-1:0]  load_sram_wb_data;
    logic [STORE_SRAM_DATA_WD-1:0] store_sram_wb_data;
    logic                          data_sram_en;
    logic [3:0]                    data_sram_wen;
    logic [31:0]                   data_sram_addr;
    logic [31:0]                   data_sram_wdata;

    modport master (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
               load_sram_wb_data, store_sram_wb_data,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );

    modport slave (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, ex_is_load, stallreq_for_ex,
               load_sram_wb_data, store_sram_wb_data,
               data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
    );
endinterface

// File: rtl/ex_stage_div.sv
// ex_div: 32-step restoring divider (IDLE -> CALC -> DONE) with signed fix-up and divide-by-zero override.
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        stall_ex,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] quo_r;
    logic [31:0] rem_r;
    logic [31:0] divisor;
    logic [31:0] dividend_raw;
    logic        neg_q;
    logic        neg_r;
    logic        by_zero;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        fits;

    assign shifted = {rem_r, quo_r[31]};
    assign diff    = shifted - {1'b0, divisor};
    assign fits    = shifted >= {1'b0, divisor};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 6'd0;
            quo_r        <= 32'd0;
            rem_r        <= 32'd0;
            divisor      <= 32'd0;
            dividend_raw <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            by_zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    quo_r        <= (signed_op && op1[31]) ? -op1 : op1;
                    divisor      <= (signed_op && op2[31]) ? -op2 : op2;
                    rem_r        <= 32'd0;
                    dividend_raw <= op1;
                    neg_q        <= signed_op & (op1[31] ^ op2[31]);
                    neg_r        <= signed_op & op1[31];
                    by_zero      <= (op2 == 32'd0);
                    cnt          <= 6'd0;
                    state        <= CALC;
                end
                CALC: begin
                    rem_r <= fits ? diff[31:0] : shifted[31:0];
                    quo_r <= {quo_r[30:0], fits};
                    cnt   <= cnt + 6'd1;
                    if (cnt == 6'd31)
                        state <= DONE;
                end
                DONE: if (!stall_ex)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = rst & (((state == IDLE) & start) | (state == CALC));
    assign done      = (state == DONE);
    assign quotient  = by_zero ? 32'hFFFF_FFFF : (neg_q ? -quo_r : quo_r);
    assign remainder = by_zero ? dividend_raw  : (neg_r ? -rem_r : rem_r);

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage (ID/EX register, ALU, HI/LO, data-SRAM request).
// Define EX_DIV_EN to instantiate the ex_div divider; otherwise div/divu are NOPs.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.master bus
);

    id_to_ex_t   id_ex;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // A stall on ID with EX free inserts a bubble; otherwise EX holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst)
            id_ex <= '0;
        else if (bus.stall[1] == Stop && bus.stall[2] == NoStop)
            id_ex <= '0;
        else if (bus.stall[2] == NoStop)
            id_ex <= bus.id_to_ex_bus;
    end

`ifdef EX_DIV_EN
    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (|id_ex.div_op),
        .signed_op (id_ex.div_op[DIV_SIGNED]),
        .op1       (id_ex.src1),
        .op2       (id_ex.src2),
        .stall_ex  (bus.stall[2]),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );
`else
    logic unused_div_op;
    assign unused_div_op = ^id_ex.div_op;
    assign div_busy      = 1'b0;
    assign div_done      = 1'b0;
    assign div_quo       = 32'd0;
    assign div_rem       = 32'd0;
`endif

    // HI/LO only change when the instruction in EX actually leaves the stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (bus.stall[2] == NoStop) begin
            if (div_done) begin
                hi <= div_rem;
                lo <= div_quo;
            end else begin
                if (id_ex.hilo_op[HILO_MTHI]) hi <= id_ex.src1;
                if (id_ex.hilo_op[HILO_MTLO]) lo <= id_ex.src1;
            end
        end
    end

    logic [31:0] add_res, sub_res, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic        is_mem, is_store, is_byte, is_half, is_word;
    logic [3:0]  mask;
    logic [31:0] wdata;

    assign add_res  = id_ex.src1 + id_ex.src2;
    assign sub_res  = id_ex.src1 - id_ex.src2;
    assign slt_res  = {31'd0, $signed(id_ex.src1) < $signed(id_ex.src2)};
    assign sltu_res = {31'd0, id_ex.src1 < id_ex.src2};
    assign sll_res  = id_ex.src2 << id_ex.src1[4:0];
    assign srl_res  = id_ex.src2 >> id_ex.src1[4:0];
    assign sra_res  = $signed(id_ex.src2) >>> id_ex.src1[4:0];
    assign lui_res  = {id_ex.src2[15:0], 16'd0};

    always_comb begin
        alu_res = ({32{id_ex.alu_op[ALU_ADD]}}  & add_res)
                | ({32{id_ex.alu_op[ALU_SUB]}}  & sub_res)
                | ({32{id_ex.alu_op[ALU_SLT]}}  & slt_res)
                | ({32{id_ex.alu_op[ALU_SLTU]}} & sltu_res)
                | ({32{id_ex.alu_op[ALU_AND]}}  & (id_ex.src1 & id_ex.src2))
                | ({32{id_ex.alu_op[ALU_NOR]}}  & ~(id_ex.src1 | id_ex.src2))
                | ({32{id_ex.alu_op[ALU_OR]}}   & (id_ex.src1 | id_ex.src2))
                | ({32{id_ex.alu_op[ALU_XOR]}}  & (id_ex.src1 ^ id_ex.src2))
                | ({32{id_ex.alu_op[ALU_SLL]}}  & sll_res)
                | ({32{id_ex.alu_op[ALU_SRL]}}  & srl_res)
                | ({32{id_ex.alu_op[ALU_SRA]}}  & sra_res)
                | ({32{id_ex.alu_op[ALU_LUI]}}  & lui_res);
    end

    assign is_store = |id_ex.store;
    assign is_mem   = (|id_ex.load) | is_store;
    assign is_byte  = id_ex.load[4] | id_ex.load[1] | id_ex.store[2];
    assign is_half  = id_ex.load[3] | id_ex.load[0] | id_ex.store[1];
    assign is_word  = id_ex.load[2] | id_ex.store[0];

    always_comb begin
        ex_result = alu_res;
        if (id_ex.hilo_op[HILO_MFHI])
            ex_result = hi;
        else if (id_ex.hilo_op[HILO_MFLO])
            ex_result = lo;
        else if (is_mem)
            ex_result = add_res;
    end

    assign mask = is_mem ? lane_mask(ex_result[1:0], is_byte, is_half, is_word) : 4'b0000;

    always_comb begin
        wdata = 32'd0;
        if (id_ex.store[2])
            wdata = {4{id_ex.rt_data[7:0]}};
        else if (id_ex.store[1])
            wdata = {2{id_ex.rt_data[15:0]}};
        else if (id_ex.store[0])
            wdata = id_ex.rt_data;
    end

    assign bus.ex_to_mem_bus      = {id_ex.pc, is_mem, mask, id_ex.sel_rf_res, id_ex.rf_we,
                                     id_ex.rf_waddr, ex_result};
    assign bus.ex_to_id_bus       = {id_ex.rf_we, id_ex.rf_waddr, ex_result};
    assign bus.ex_is_load         = |id_ex.load;
    assign bus.stallreq_for_ex    = div_busy;
    assign bus.load_sram_wb_data  = id_ex.load;
    assign bus.store_sram_wb_data = id_ex.store;
    assign bus.data_sram_en       = is_mem & ~div_busy;
    assign bus.data_sram_wen      = (is_store & ~div_busy) ? mask : 4'b0000;
    assign bus.data_sram_addr     = ex_result;
    assign bus.data_sram_wdata    = wdata;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, between the ID/EX boundary and the MEM stage. It registers the decoded instruction, computes the ALU result, and issues the data-SRAM request for loads and stores. It produces the lane mask and load/store one-hot buses that MEM needs to extract load data. It also owns the HI/LO registers and a 32-iteration signed/unsigned divider that stalls the front of the pipeline while it runs.

## Interface
Parameters: none. All widths come from `lib/defines.vh`.
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock; synchronous, active-low
- stall  in  `StallBus  per-stage stall vector; bit 1 = ID, bit 2 = EX, bit 3 = MEM
- id_to_ex_bus  in  `ID_TO_EX_WD (161)  fields, MSB first:
  - pc[32]
  - alu_op[12], one-hot: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui
  - div_op[2]: {div, divu}
  - hilo_op[4]: {mfhi, mflo, mthi, mtlo}
  - load[5]: {lb, lh, lw, lbu, lhu}
  - store[3]: {sb, sh, sw}
  - sel_rf_res, rf_we, rf_waddr[5]
  - src1[32], src2[32], rt_data[32]
- ex_to_mem_bus  out  76  {pc, data_ram_en, data_ram_wen[4], sel_rf_res, rf_we, rf_waddr, ex_result}
- ex_to_id_bus  out  38  {rf_we, rf_waddr, ex_result}; forwarding path
- ex_is_load  out  1  current EX instruction is a load; used for load-use stall
- stallreq_for_ex  out  1  divider busy
- load_sram_wb_data  out  5  load one-hot of the current EX instruction
- store_sram_wb_data  out  3  store one-hot of the current EX instruction
- data_sram_en  out  1  SRAM access enable
- data_sram_wen  out  4  SRAM byte write enables; stores only
- data_sram_addr  out  32  byte address
- data_sram_wdata  out  32  store data, lane-replicated

## Operation
- **ID/EX register update**, in priority order:
  - rst low: clear to 0.
  - stall[1]=Stop and stall[2]=NoStop: load 0 (bubble).
  - stall[2]=NoStop: load id_to_ex_bus.
  - otherwise: hold.
- **ALU**: selects per one-hot alu_op.
  - Shifts use src1[4:0] as the amount and src2 as the data.
  - lui gives {src2[15:0], 16'b0}.
  - No overflow trap.
  - An all-zero alu_op gives 0.
- **ex_result**:
  - mfhi gives HI; mflo gives LO.
  - Otherwise the ALU result.
  - For loads and stores the ALU add result is the address.
- **Lane mask** from addr[1:0]:
  - Byte access: one-hot lane, addr 0→4'b0001 through 3→4'b1000.
  - Halfword: addr[1]=0 gives 0011, addr[1]=1 gives 1100; addr[0] is ignored.
  - Word: 1111; addr[1:0] is ignored.
  - No alignment exception.
- **Memory request and bus fields**:
  - data_ram_en = any load or store. The mask is carried on the bus for both loads and stores.
  - data_sram_wen = mask when a store is active, else 0.
  - data_sram_wdata: sb gives {4{rt_data[7:0]}}, sh gives {2{rt_data[15:0]}}, sw gives rt_data.
  - data_sram_addr = ex_result.
- **SRAM gating**: data_sram_en is forced 0 while stallreq_for_ex=1.
- **HI/LO**:
  - mthi writes HI←src1; mtlo writes LO←src1.
  - Writes take effect at the edge where stall[2]=NoStop.
  - mfhi in the next instruction sees the new value.
- **Divider FSM** (ex_div): states IDLE → CALC → DONE.
  - IDLE with div_op≠0: latch operand magnitudes and signs, clear counter, go to CALC.
  - CALC: one restoring step per cycle. After 32 steps go to DONE.
  - DONE: apply signs and drive the result valid. If stall[2]=NoStop, go to IDLE and write HI=remainder, LO=quotient.
  - Signed division: quotient sign = sign1 XOR sign2; remainder takes the dividend's sign.
  - 0x80000000 / −1 gives LO=0x80000000, HI=0.
  - Divide by zero gives LO=0xFFFFFFFF, HI=dividend; no trap.
- **stallreq_for_ex** = (IDLE and div_op≠0) or CALC.
- **Reset mid-divide**: FSM returns to IDLE, HI/LO clear, stallreq drops in the same cycle rst is sampled.

## Timing
- **Reset values**:
  - All registers and HI/LO are 0.
  - Every output is 0, including stallreq_for_ex.
- **ALU path**: combinational from the ID/EX register. Zero cycles inside EX; one cycle from id_to_ex_bus.
- **Divide occupies EX for 34 cycles**:
  - Cycle 0 (IDLE): stallreq=1.
  - Cycles 1–32 (CALC): stallreq=1.
  - Cycle 33 (DONE): stallreq=0; HI/LO written at the end of cycle 33.
- **Downstream during a divide stall**: with stall=000111, MEM receives bubbles. No SRAM access is issued.
- **Back-to-back divides**: the second starts IDLE→CALC in the cycle after DONE, with no idle gap.
- **External stall in DONE**: if stall[2]=Stop in DONE, the FSM holds DONE with its result. It writes HI/LO once, when stall releases.
- **Repeated SRAM requests**: a load or store held by an external EX stall re-asserts the same request each cycle. This is idempotent.

## Configuration
- `EX_DIV_EN` defined:
  - Divider instantiated; behaviour as above.
- `EX_DIV_EN` undefined:
  - ex_div is not instantiated; stallreq_for_ex is tied to 0.
  - div/divu behave as NOPs: HI/LO unchanged, rf_we as decoded.
  - mthi, mtlo, mfhi and mflo still work.

## Structure
- Add to `lib/defines.vh`:
  - `ID_TO_EX_WD`=161, `EX_TO_MEM_WD`=76, `EX_TO_ID_WD`=38.
  - `LOAD_SRAM_DATA_WD`=5, `STORE_SRAM_DATA_WD`=3.
  - ALU one-hot bit indices.
  - `Stop`/`NoStop` (already present).
- Sub-module ex_div:
  - Inputs: clk, rst, start, signed_op, op1, op2, stall_ex.
  - Outputs: busy, done, quotient, remainder.
  - Owns the FSM and the 6-bit counter.
- HI/LO registers stay in ex_stage.

## Test plan
- **ALU ops and reset**: drive each ALU op through with stall=0.
  - add src1=0x7FFFFFFF, src2=1 → ex_result=0x80000000; no trap.
  - sra src1=4, src2=0xF0000000 → 0xFF000000.
  - Reset → all outputs 0.
- **Store lane mask and data**: sb, addr 0x1003, rt_data=0x12345678 → data_sram_wen=1000, wdata=0x78787878. sh, addr 0x1002 → wen=1100, wdata=0x56785678.
- **Load request**: lh, addr 0x2002 → data_sram_en=1, data_sram_wen=0, bus data_ram_wen=1100, ex_is_load=1, load_sram_wb_data=5'b01000.
- **Signed divide**: div −7/2.
  - stallreq=1 for exactly 33 cycles.
  - In the following cycle, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - A following mflo gives ex_result=0xFFFFFFFD.
- **Unsigned divide by zero**: divu 0xFFFFFFFF/0 → LO=0xFFFFFFFF, HI=0xFFFFFFFF. An EX stall held in DONE for 3 cycles writes HI/LO once, on release.
- **Reset mid-divide**: rst low at CALC cycle 10 → stallreq=0 and HI=LO=0 after the edge. With `EX_DIV_EN` undefined, div leaves HI/LO unchanged and stallreq stays 0.
